// File: rtl/fb_arb_pkg.sv
// Shared types and defaults for the framebuffer write arbiter and its fill engine.
package fb_arb_pkg;

  localparam int FB_ADDR_W = 12;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    SRC_CPU = 2'd0,
    SRC_DMA = 2'd1,
    SRC_CLR = 2'd2
  } fb_src_e;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_FILL = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_e;

  // Round-robin successor in the order CPU -> DMA -> CLR -> CPU.
  function automatic fb_src_e next_src(input fb_src_e s);
    case (s)
      SRC_CPU: return SRC_DMA;
      SRC_DMA: return SRC_CLR;
      default: return SRC_CPU;
    endcase
  endfunction

endpackage

// File: rtl/fb_clear_engine.sv
// Fill engine: writes a latched value over an address range, one word per grant,
// wrapping modulo 2^ADDR_W.
module fb_clear_engine
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [ADDR_W:0]   len_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              grant_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  clr_state_e        state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] last_q;
  logic [DATA_W-1:0] data_q;
  logic [ADDR_W:0]   len_eff;
  logic [ADDR_W-1:0] last_d;

  // Oversized lengths clamp to a full sweep; last_d is the index of the final word.
  assign len_eff = (len_i > LEN_MAX) ? LEN_MAX : len_i;
  assign last_d  = ADDR_W'(len_eff - (ADDR_W+1)'(1));

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        CLR_IDLE: begin
          if (start_i) begin
            base_q  <= base_i;
            data_q  <= data_i;
            last_q  <= last_d;
            cnt_q   <= '0;
            state_q <= (len_i == '0) ? CLR_DONE : CLR_FILL;
          end
        end
        CLR_FILL: begin
          if (grant_i) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == last_q) begin
              state_q <= CLR_DONE;
            end
          end
        end
        CLR_DONE: begin
          cnt_q   <= '0;
          state_q <= CLR_IDLE;
        end
        default: begin
          state_q <= CLR_IDLE;
        end
      endcase
    end
  end

  assign valid_o = (state_q == CLR_FILL);
  assign addr_o  = base_q + cnt_q;
  assign data_o  = data_q;
  assign busy_o  = (state_q != CLR_IDLE);
  assign done_o  = (state_q == CLR_DONE);

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the framebuffer write port between CPU, DMA and the
// fill engine; the fill engine is compiled in only when FB_ARB_CLEAR_EN is defined.
module fb_write_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W = FB_ADDR_W,
  parameter int DATA_W = FB_DATA_W
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_data,
  output logic              dma_ack,
  input  logic              clr_start,
  input  logic [ADDR_W-1:0] clr_base,
  input  logic [ADDR_W:0]   clr_len,
  input  logic [DATA_W-1:0] clr_data,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [DATA_W-1:0] fb_data,
  output logic              fb_we
);

  logic              clr_valid;
  logic              clr_grant;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_wdata;

`ifdef FB_ARB_CLEAR_EN
  localparam fb_src_e LAST_RST = SRC_CLR;

  fb_clear_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_clear (
    .clk50   (clk50),
    .rst     (rst),
    .start_i (clr_start),
    .base_i  (clr_base),
    .len_i   (clr_len),
    .data_i  (clr_data),
    .grant_i (clr_grant),
    .valid_o (clr_valid),
    .addr_o  (clr_addr),
    .data_o  (clr_wdata),
    .busy_o  (clr_busy),
    .done_o  (clr_done)
  );
`else
  localparam fb_src_e LAST_RST = SRC_DMA;

  logic unused_clr;
  assign unused_clr = ^{clr_start, clr_base, clr_len, clr_data, clr_grant};
  assign clr_valid  = 1'b0;
  assign clr_addr   = '0;
  assign clr_wdata  = '0;
  assign clr_busy   = 1'b0;
  assign clr_done   = 1'b0;
`endif

  fb_src_e           last_grant_q;
  fb_src_e           grant_src;
  fb_src_e           cand;
  logic              grant_any;
  logic              cand_ok;
  logic              elig_cpu;
  logic              elig_dma;
  logic              elig_clr;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [DATA_W-1:0] wr_data_d;
  logic [ADDR_W-1:0] fb_addr_q;
  logic [DATA_W-1:0] fb_data_q;
  logic              fb_we_q;

  // Acks are combinational, so requests are masked while reset is held.
  assign elig_cpu = cpu_req   & ~rst;
  assign elig_dma = dma_req   & ~rst;
  assign elig_clr = clr_valid & ~rst;

  always_comb begin
    grant_any = 1'b0;
    grant_src = last_grant_q;
    cand      = last_grant_q;
    cand_ok   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cand = next_src(cand);
      case (cand)
        SRC_CPU: cand_ok = elig_cpu;
        SRC_DMA: cand_ok = elig_dma;
        default: cand_ok = elig_clr;
      endcase
      if (!grant_any && cand_ok) begin
        grant_any = 1'b1;
        grant_src = cand;
      end
    end
  end

  assign cpu_ack   = grant_any && (grant_src == SRC_CPU);
  assign dma_ack   = grant_any && (grant_src == SRC_DMA);
  assign clr_grant = grant_any && (grant_src == SRC_CLR);

  always_comb begin
    wr_addr_d = cpu_addr;
    wr_data_d = cpu_data;
    case (grant_src)
      SRC_DMA: begin
        wr_addr_d = dma_addr;
        wr_data_d = dma_data;
      end
      SRC_CLR: begin
        wr_addr_d = clr_addr;
        wr_data_d = clr_wdata;
      end
      default: ;
    endcase
  end

  // Address/data hold their last value when no write is issued.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      last_grant_q <= LAST_RST;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_data_q    <= '0;
    end else begin
      fb_we_q <= grant_any;
      if (grant_any) begin
        last_grant_q <= grant_src;
        fb_addr_q    <= wr_addr_d;
        fb_data_q    <= wr_data_d;
      end
    end
  end

  assign fb_we   = fb_we_q;
  assign fb_addr = fb_addr_q;
  assign fb_data = fb_data_q;

endmodule
